reaction_round_sequencer: RTL and testbench

Round controller for the reaction-time game. It sequences one round: a random delay, then the armed/timing phase, then the result. It timestamps the hit in milliseconds and schedules all accesses to the shared 4x13-bit score register file. The register file holds reg0 = attempt count, reg1 = best time, reg2 = last time. The block sits between the debounced buttons/LEDs/display and the register file, and is the only master of the register file.

---
 rtl/reaction_round_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_reaction_round_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_round_sequencer.sv
// Round controller for the reaction-time game: random pre-arm delay, armed timing phase,
// result writeback, and sole master of the 4x13-bit score register file.
module reaction_round_sequencer #(
    parameter int TICK_DIV         = 50000,
    parameter int MIN_DELAY_MS     = 1000,
    parameter int DELAY_RANGE_BITS = 11
) (
    input  logic        Clock,
    input  logic        CLRN,
    input  logic        buttonStart,
    input  logic        buttonHit,
    input  logic        buttonReset,
    input  logic [12:0] regReadData,
    output logic [1:0]  regAddr,
    output logic        regWrite,
    output logic [12:0] regWriteData,
    output logic        ledGreen,
    output logic        RedLed,
    output logic [12:0] DisplayScore,
    output logic [1:0]  DisplayScoreControl,
    output logic        busy
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_TERM   = PS_W'(TICK_DIV - 1);
    localparam logic [12:0]     SCORE_MAX = 13'h1FFF;

    typedef enum logic [3:0] {
        S_IDLE, S_DELAY, S_ARMED, S_FALSE, S_WB_LAST, S_RD_BEST, S_WB_BEST,
        S_RD_CNT, S_WB_CNT, S_SHOW, S_CLR0, S_CLR1, S_CLR2
    } state_t;

    state_t            r_state;
    state_t            w_nstate;
    logic              r_start_q, r_hit_q, r_rst_q, r_edge_en;
    logic [15:0]       r_lfsr;
    logic [PS_W-1:0]   r_presc;
    logic [15:0]       r_delay;
    logic [12:0]       r_ms, r_T;
    logic              r_timeout, r_newbest;
    logic [1:0]        r_regAddr;
    logic              r_regWrite;
    logic [12:0]       r_wdata, r_disp;
    logic [1:0]        r_ctrl;
    logic              r_green, r_red, r_busy;

    logic              w_start_e, w_hit_e, w_rst_e, w_tick, w_best, w_lfsr_fb, w_entering;
    logic [15:0]       w_delay_load;

    function automatic logic [12:0] f_sat_inc(input logic [12:0] v);
        return (v == SCORE_MAX) ? SCORE_MAX : v + 13'd1;
    endfunction

    // Edges are masked for the first cycle after reset so buttons held through reset stay silent.
    assign w_start_e    = r_edge_en & buttonStart & ~r_start_q;
    assign w_hit_e      = r_edge_en & buttonHit   & ~r_hit_q;
    assign w_rst_e      = r_edge_en & buttonReset & ~r_rst_q;
    assign w_tick       = (r_presc == PS_TERM);
    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_delay_load = 16'(MIN_DELAY_MS) + 16'(r_lfsr[DELAY_RANGE_BITS-1:0]);
    assign w_best       = !r_timeout && ((regReadData == 13'd0) || (r_T < regReadData));
    assign w_entering   = (w_nstate != r_state);

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_e)      w_nstate = S_DELAY;
                else if (w_rst_e)   w_nstate = S_CLR0;
            end
            S_DELAY: begin
                if (w_hit_e)                          w_nstate = S_FALSE;
                else if (w_rst_e)                     w_nstate = S_IDLE;
                else if (w_tick && r_delay < 16'd2)   w_nstate = S_ARMED;
            end
            S_ARMED: begin
                if (w_hit_e)                  w_nstate = S_WB_LAST;
                else if (w_rst_e)             w_nstate = S_IDLE;
                else if (r_ms == SCORE_MAX)   w_nstate = S_WB_LAST;
            end
            S_FALSE, S_SHOW: begin
                if (w_start_e)      w_nstate = S_DELAY;
                else if (w_rst_e)   w_nstate = S_CLR0;
            end
            S_WB_LAST: w_nstate = S_RD_BEST;
            S_RD_BEST: w_nstate = w_best ? S_WB_BEST : S_RD_CNT;
            S_WB_BEST: w_nstate = S_RD_CNT;
            S_RD_CNT:  w_nstate = S_WB_CNT;
            S_WB_CNT:  w_nstate = S_SHOW;
            S_CLR0:    w_nstate = S_CLR1;
            S_CLR1:    w_nstate = S_CLR2;
            S_CLR2:    w_nstate = S_IDLE;
            default:   w_nstate = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_hit_q    <= 1'b0;
            r_rst_q    <= 1'b0;
            r_edge_en  <= 1'b0;
            r_lfsr     <= 16'hACE1;
            r_presc    <= '0;
            r_delay    <= 16'd0;
            r_ms       <= 13'd0;
            r_T        <= 13'd0;
            r_timeout  <= 1'b0;
            r_newbest  <= 1'b0;
            r_regAddr  <= 2'b01;
            r_regWrite <= 1'b0;
            r_wdata    <= 13'd0;
            r_disp     <= 13'd0;
            r_ctrl     <= 2'b00;
            r_green    <= 1'b0;
            r_red      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_start_q <= buttonStart;
            r_hit_q   <= buttonHit;
            r_rst_q   <= buttonReset;
            r_edge_en <= 1'b1;
            r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};

            if (w_entering && (w_nstate == S_DELAY || w_nstate == S_ARMED))
                r_presc <= '0;
            else if (w_tick)
                r_presc <= '0;
            else
                r_presc <= r_presc + PS_W'(1);

            if (w_entering && w_nstate == S_DELAY)
                r_delay <= w_delay_load;
            else if (r_state == S_DELAY && w_tick && r_delay != 16'd0)
                r_delay <= r_delay - 16'd1;

            if (w_entering && w_nstate == S_ARMED)
                r_ms <= 13'd0;
            else if (r_state == S_ARMED && w_tick && r_ms != SCORE_MAX)
                r_ms <= r_ms + 13'd1;

            if (w_entering && w_nstate == S_DELAY) begin
                r_timeout <= 1'b0;
                r_newbest <= 1'b0;
            end else if (r_state == S_ARMED && w_nstate == S_WB_LAST) begin
                r_T       <= w_hit_e ? r_ms : SCORE_MAX;
                r_timeout <= !w_hit_e;
                r_newbest <= 1'b0;
            end else if (r_state == S_WB_BEST) begin
                r_newbest <= 1'b1;
            end

            case (w_nstate)
                S_WB_LAST:                  r_regAddr <= 2'b10;
                S_RD_CNT, S_WB_CNT, S_CLR0: r_regAddr <= 2'b00;
                S_CLR2:                     r_regAddr <= 2'b10;
                default:                    r_regAddr <= 2'b01;
            endcase

            r_regWrite <= (w_nstate == S_WB_LAST) || (w_nstate == S_WB_BEST) ||
                          (w_nstate == S_WB_CNT)  || (w_nstate == S_CLR0) ||
                          (w_nstate == S_CLR1)    || (w_nstate == S_CLR2);

            // The count read in RD_CNT feeds the increment directly on the way into WB_CNT.
            case (w_nstate)
                S_WB_LAST: r_wdata <= w_hit_e ? r_ms : SCORE_MAX;
                S_WB_BEST: r_wdata <= r_T;
                S_WB_CNT:  r_wdata <= f_sat_inc(regReadData);
                default:   r_wdata <= 13'd0;
            endcase

            case (w_nstate)
                S_IDLE: begin
                    r_disp <= regReadData;
                    r_ctrl <= 2'b00;
                end
                S_FALSE: begin
                    r_disp <= SCORE_MAX;
                    r_ctrl <= 2'b11;
                end
                S_SHOW: begin
                    r_disp <= r_T;
                    r_ctrl <= r_timeout ? 2'b11 : (r_newbest ? 2'b10 : 2'b01);
                end
                default: ;
            endcase

            r_green <= (w_nstate == S_ARMED);
            r_red   <= (w_nstate == S_DELAY) || (w_nstate == S_FALSE);
            r_busy  <= !((w_nstate == S_IDLE) || (w_nstate == S_SHOW));
        end
    end

    assign regAddr             = r_regAddr;
    assign regWrite            = r_regWrite;
    assign regWriteData        = r_wdata;
    assign ledGreen            = r_green;
    assign RedLed              = r_red;
    assign DisplayScore        = r_disp;
    assign DisplayScoreControl = r_ctrl;
    assign busy                = r_busy;

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Bench for reaction_round_sequencer: models the score register file and the game's
// scoring rules, plays randomized rounds and checks display, LEDs and register contents.
module tb_reaction_round_sequencer;

    localparam int TICK = 4;
    localparam int MIND = 2;
    localparam int DRB  = 2;

    logic        Clock;
    logic        CLRN;
    logic        buttonStart, buttonHit, buttonReset;
    logic [12:0] regReadData, regWriteData, DisplayScore;
    logic [1:0]  regAddr, DisplayScoreControl;
    logic        regWrite, ledGreen, RedLed, busy;

    logic [12:0] rf [0:3] = '{default: 13'd0};
    int          wr_n = 0;
    logic [1:0]  log_a [0:255];
    logic [12:0] log_d [0:255];

    int total = 0;
    int bad   = 0;
    int exp_best = 0, exp_last = 0, exp_cnt = 0;

    reaction_round_sequencer #(
        .TICK_DIV(TICK), .MIN_DELAY_MS(MIND), .DELAY_RANGE_BITS(DRB)
    ) dut (
        .Clock(Clock), .CLRN(CLRN),
        .buttonStart(buttonStart), .buttonHit(buttonHit), .buttonReset(buttonReset),
        .regReadData(regReadData), .regAddr(regAddr), .regWrite(regWrite),
        .regWriteData(regWriteData), .ledGreen(ledGreen), .RedLed(RedLed),
        .DisplayScore(DisplayScore), .DisplayScoreControl(DisplayScoreControl), .busy(busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    assign regReadData = rf[regAddr];

    always @(posedge Clock) begin
        if (regWrite === 1'b1) begin
            rf[regAddr]        <= regWriteData;
            log_a[wr_n & 255]  <= regAddr;
            log_d[wr_n & 255]  <= regWriteData;
            wr_n               <= wr_n + 1;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Game scoring rules: last time always recorded, best replaced only by a faster real hit.
    function automatic logic [1:0] model_round(input int t, input bit to);
        logic [1:0] c;
        exp_last = t;
        if (!to && (exp_best == 0 || t < exp_best)) begin
            exp_best = t;
            c = 2'b10;
        end else begin
            c = to ? 2'b11 : 2'b01;
        end
        exp_cnt = (exp_cnt >= 8191) ? 8191 : exp_cnt + 1;
        return c;
    endfunction

    task automatic pulse(input int which);
        case (which)
            0: buttonStart = 1'b1;
            1: buttonHit   = 1'b1;
            default: buttonReset = 1'b1;
        endcase
        @(negedge Clock);
        buttonStart = 1'b0;
        buttonHit   = 1'b0;
        buttonReset = 1'b0;
    endtask

    // Starts a round, waits for the green LED, hits d cycles later (d<0: never), waits for SHOW.
    task automatic play_round(input int d, output int k, output bit ok);
        int n;
        ok = 1'b0;
        pulse(0);
        k = 1;
        while (k < 200 && ledGreen !== 1'b1) begin
            @(negedge Clock);
            k++;
        end
        if (ledGreen !== 1'b1) return;
        if (d >= 0) begin
            repeat (d) @(negedge Clock);
            pulse(1);
        end
        n = 0;
        while (n < 40000 && busy !== 1'b0) begin
            @(negedge Clock);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset;
        CLRN = 1'b0;
        buttonStart = 1'b0;
        buttonHit   = 1'b0;
        buttonReset = 1'b0;
        repeat (3) @(negedge Clock);
        total++;
        if (regWrite !== 1'b0 || regAddr !== 2'b01) begin
            bad++;
            $display("FAIL reset_reg_port: got we=%b addr=%b want we=0 addr=01", regWrite, regAddr);
        end
        total++;
        if (ledGreen !== 1'b0 || RedLed !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_leds_busy: got g=%b r=%b busy=%b want 0 0 0", ledGreen, RedLed, busy);
        end
        total++;
        if (DisplayScore !== 13'd0 || DisplayScoreControl !== 2'b00) begin
            bad++;
            $display("FAIL reset_display: got %0d/%b want 0/00", DisplayScore, DisplayScoreControl);
        end
        CLRN = 1'b1;
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_round(input string nm, input int d);
        int k, t, w0;
        bit ok, to;
        logic [1:0] ec;
        w0 = wr_n;
        play_round(d, k, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_reach_show: got not reached want SHOW", nm);
            return;
        end
        total++;
        if ((k - 1) % TICK != 0 || (k - 1) / TICK < MIND || (k - 1) / TICK > MIND + (1 << DRB) - 1) begin
            bad++;
            $display("FAIL %s_delay_len: got %0d cycles want 4*[%0d..%0d]", nm, k - 1, MIND, MIND + (1 << DRB) - 1);
        end
        to = (d < 0);
        t  = to ? 8191 : d / TICK;
        ec = model_round(t, to);
        total++;
        if (DisplayScore !== 13'(exp_last) || DisplayScoreControl !== ec) begin
            bad++;
            $display("FAIL %s_show: got %0d/%b want %0d/%b", nm, DisplayScore, DisplayScoreControl, exp_last, ec);
        end
        total++;
        if (rf[2] !== 13'(exp_last) || rf[1] !== 13'(exp_best) || rf[0] !== 13'(exp_cnt)) begin
            bad++;
            $display("FAIL %s_regs: got last=%0d best=%0d cnt=%0d want %0d %0d %0d",
                     nm, rf[2], rf[1], rf[0], exp_last, exp_best, exp_cnt);
        end
        total++;
        if (wr_n - w0 != ((ec == 2'b10) ? 3 : 2)) begin
            bad++;
            $display("FAIL %s_write_count: got %0d want %0d", nm, wr_n - w0, (ec == 2'b10) ? 3 : 2);
        end
    endtask

    task automatic test_idle_after_abort;
        int w0;
        w0 = wr_n;
        pulse(0);
        @(negedge Clock);
        pulse(2);
        repeat (4) @(negedge Clock);
        total++;
        if (busy !== 1'b0 || RedLed !== 1'b0 || DisplayScore !== 13'(exp_best) || DisplayScoreControl !== 2'b00) begin
            bad++;
            $display("FAIL idle_view: got busy=%b red=%b disp=%0d ctl=%b want 0 0 %0d 00",
                     busy, RedLed, DisplayScore, DisplayScoreControl, exp_best);
        end
        total++;
        if (wr_n != w0) begin
            bad++;
            $display("FAIL abort_no_write: got %0d writes want 0", wr_n - w0);
        end
    endtask

    task automatic test_false_start;
        int w0;
        w0 = wr_n;
        pulse(0);
        @(negedge Clock);
        pulse(1);
        total++;
        if (RedLed !== 1'b1 || ledGreen !== 1'b0 || DisplayScore !== 13'd8191 || DisplayScoreControl !== 2'b11) begin
            bad++;
            $display("FAIL false_view: got red=%b grn=%b disp=%0d ctl=%b want 1 0 8191 11",
                     RedLed, ledGreen, DisplayScore, DisplayScoreControl);
        end
        pulse(0);
        total++;
        if (RedLed !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL false_restart: got red=%b busy=%b want 1 1", RedLed, busy);
        end
        pulse(2);
        @(negedge Clock);
        total++;
        if (wr_n != w0 || rf[1] !== 13'(exp_best) || rf[0] !== 13'(exp_cnt)) begin
            bad++;
            $display("FAIL false_no_write: got writes=%0d best=%0d cnt=%0d want 0 %0d %0d",
                     wr_n - w0, rf[1], rf[0], exp_best, exp_cnt);
        end
    endtask

    task automatic test_clear;
        int w0;
        bit okw;
        w0 = wr_n;
        pulse(2);
        repeat (5) @(negedge Clock);
        okw = (wr_n - w0 == 3);
        if (okw)
            for (int i = 0; i < 3; i++)
                if (log_a[(w0 + i) & 255] !== 2'(i) || log_d[(w0 + i) & 255] !== 13'd0) okw = 1'b0;
        total++;
        if (!okw) begin
            bad++;
            $display("FAIL clear_writes: got %0d writes first_addr=%0d want 3 zero writes to 0,1,2",
                     wr_n - w0, log_a[w0 & 255]);
        end
        exp_best = 0;
        exp_last = 0;
        exp_cnt  = 0;
        total++;
        if (busy !== 1'b0 || DisplayScore !== 13'd0 || DisplayScoreControl !== 2'b00 ||
            rf[0] !== 13'd0 || rf[1] !== 13'd0 || rf[2] !== 13'd0) begin
            bad++;
            $display("FAIL clear_idle: got busy=%b disp=%0d ctl=%b want 0 0 00", busy, DisplayScore, DisplayScoreControl);
        end
    endtask

    task automatic test_simultaneous;
        int w0;
        w0 = wr_n;
        buttonStart = 1'b1;
        buttonReset = 1'b1;
        @(negedge Clock);
        buttonStart = 1'b0;
        buttonReset = 1'b0;
        total++;
        if (RedLed !== 1'b1 || busy !== 1'b1 || regWrite !== 1'b0) begin
            bad++;
            $display("FAIL simul_start_wins: got red=%b busy=%b we=%b want 1 1 0", RedLed, busy, regWrite);
        end
        @(negedge Clock);
        pulse(2);
        @(negedge Clock);
        total++;
        if (busy !== 1'b0 || wr_n != w0) begin
            bad++;
            $display("FAIL simul_no_clear: got busy=%b writes=%0d want 0 0", busy, wr_n - w0);
        end
    endtask

    task automatic test_async_reset;
        int k, w0;
        k = 0;
        pulse(0);
        while (k < 200 && ledGreen !== 1'b1) begin
            @(negedge Clock);
            k++;
        end
        repeat (12) @(negedge Clock);
        pulse(1);
        repeat (2) @(negedge Clock);
        total++;
        if (regWrite !== 1'b1 || regAddr !== 2'b01 || regWriteData !== 13'd3) begin
            bad++;
            $display("FAIL async_in_wb_best: got we=%b addr=%b data=%0d want 1 01 3", regWrite, regAddr, regWriteData);
        end
        buttonStart = 1'b1;
        buttonHit   = 1'b1;
        buttonReset = 1'b1;
        #2 CLRN = 1'b0;
        #1;
        total++;
        if (regWrite !== 1'b0 || busy !== 1'b0 || RedLed !== 1'b0 || ledGreen !== 1'b0) begin
            bad++;
            $display("FAIL async_drop: got we=%b busy=%b red=%b grn=%b want 0 0 0 0", regWrite, busy, RedLed, ledGreen);
        end
        repeat (2) @(negedge Clock);
        exp_last = 3;
        total++;
        if (rf[1] !== 13'd0 || rf[2] !== 13'(exp_last) || rf[0] !== 13'd0) begin
            bad++;
            $display("FAIL async_regs: got best=%0d last=%0d cnt=%0d want 0 3 0", rf[1], rf[2], rf[0]);
        end
        w0 = wr_n;
        CLRN = 1'b1;
        repeat (10) @(negedge Clock);
        total++;
        if (busy !== 1'b0 || RedLed !== 1'b0 || wr_n != w0 || DisplayScore !== 13'd0) begin
            bad++;
            $display("FAIL held_buttons_silent: got busy=%b red=%b writes=%0d disp=%0d want 0 0 0 0",
                     busy, RedLed, wr_n - w0, DisplayScore);
        end
        buttonStart = 1'b0;
        buttonHit   = 1'b0;
        buttonReset = 1'b0;
        @(negedge Clock);
    endtask

    initial begin
        test_reset();
        test_round("normal", 20);
        test_round("slower", 36);
        test_idle_after_abort();
        for (int i = 0; i < 4; i++) test_round("random", int'($urandom_range(4, 80)));
        test_false_start();
        test_round("timeout", -1);
        test_clear();
        test_simultaneous();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
